// File: rtl/regfile_wb_buffer_pkg.sv
// Shared definitions for the register-file writeback buffer: default
// widths, the hard-wired zero register and the queue entry layout.
package regfile_wb_buffer_pkg;

  localparam int N_DEF     = 5;
  localparam int M_DEF     = 32;
  localparam int DEPTH_DEF = 4;

  // Architectural zero register; writes to it are discarded at the input.
  localparam int unsigned REG_X0 = 0;

  // Queue entry layout at default widths: {rd, wd}.
  typedef struct packed {
    logic [N_DEF-1:0] rd;
    logic [M_DEF-1:0] wd;
  } wb_entry_t;

  // Number of free slots for a given occupancy.
  function automatic int unsigned free_slots(input int unsigned depth,
                                             input int unsigned occupied);
    return depth - occupied;
  endfunction

endpackage

// File: rtl/regfile_wb_buffer_wb_fifo.sv
// Circular writeback queue: up to two pushes (push0 older than push1) and
// one pop per cycle. Exposes the occupied entries in age order (index 0 is
// the head) so the top level can drive the write port and search for
// forwarding matches. Storage is not reset; only pointers and count are.
module regfile_wb_buffer_wb_fifo
  import regfile_wb_buffer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push0_i,
  input  logic [N-1:0]                  push0_rd_i,
  input  logic [M-1:0]                  push0_wd_i,
  input  logic                          push1_i,
  input  logic [N-1:0]                  push1_rd_i,
  input  logic [M-1:0]                  push1_wd_i,
  input  logic                          pop_i,
  output logic [DEPTH-1:0][N-1:0]       age_rd_o,
  output logic [DEPTH-1:0][M-1:0]       age_wd_o,
  output logic [DEPTH-1:0]              age_vld_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]  rd_mem_q [DEPTH];
  logic [M-1:0]  wd_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          pop_eff;
  logic          push1_eff;

  // An empty queue has nothing to pop; push1 is only meaningful behind push0.
  assign pop_eff   = pop_i && (count_q != '0);
  assign push1_eff = push1_i && push0_i;

  // Next-state pointers and occupancy for 2-push / 1-pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_eff);
    rd_ptr_d = rd_ptr_q + PW'(pop_eff);
    count_d  = count_q + CW'(push0_i) + CW'(push1_eff) - CW'(pop_eff);
  end

  // Control state: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: push0 lands at the write pointer, push1 right behind it.
  always_ff @(posedge clk) begin
    if (push0_i) begin
      rd_mem_q[wr_ptr_q] <= push0_rd_i;
      wd_mem_q[wr_ptr_q] <= push0_wd_i;
    end
    if (push1_eff) begin
      rd_mem_q[wr_ptr_q + PW'(1)] <= push1_rd_i;
      wd_mem_q[wr_ptr_q + PW'(1)] <= push1_wd_i;
    end
  end

  // Age-ordered view: slot i is the i-th oldest entry, valid when i < count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_rd_o[i]  = rd_mem_q[rd_ptr_q + PW'(i)];
      age_wd_o[i]  = wd_mem_q[rd_ptr_q + PW'(i)];
      age_vld_o[i] = (CW'(i) < count_q);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_buffer.sv
// Write-side front end of the register file. Merges load and ALU writeback
// requests into an in-order queue (load older when both arrive together),
// filters writes to x0, raises stall when fewer than two slots are free,
// and drains one entry per cycle onto the we/a3/wd3 write port.
// Optional feature macro: WB_FORWARD_EN builds the decode-stage forwarding
// search over queued entries; without it the forwarding outputs are zero.
module regfile_wb_buffer
  import regfile_wb_buffer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  input  logic [N-1:0]           ld_rd,
  input  logic [M-1:0]           ld_wd,
  input  logic                   alu_valid,
  input  logic [N-1:0]           alu_rd,
  input  logic [M-1:0]           alu_wd,
  output logic                   stall,
  output logic                   overflow,
  output logic                   rf_we,
  output logic [N-1:0]           rf_a3,
  output logic [M-1:0]           rf_wd3,
  input  logic [N-1:0]           fwd_a1,
  input  logic [N-1:0]           fwd_a2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [M-1:0]           fwd_d1,
  output logic [M-1:0]           fwd_d2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                     ld_ok;
  logic                     alu_ok;
  logic                     push0;
  logic                     push1;
  logic [N-1:0]             push0_rd;
  logic [M-1:0]             push0_wd;
  logic [DEPTH-1:0][N-1:0]  age_rd;
  logic [DEPTH-1:0][M-1:0]  age_wd;
  logic [DEPTH-1:0]         age_vld;
  logic [CW-1:0]            count_q;
  logic                     overflow_q, overflow_d;

  // Stall comes from registered occupancy only: fewer than two free slots.
  assign stall = (free_slots(DEPTH, 32'(count_q)) < 2);

  // Accept a request only when not stalled and not targeting x0.
  assign ld_ok  = ld_valid  && !stall && (ld_rd  != N'(REG_X0));
  assign alu_ok = alu_valid && !stall && (alu_rd != N'(REG_X0));

  // Compact accepted requests: the load always takes the older slot.
  always_comb begin
    push0    = ld_ok || alu_ok;
    push1    = ld_ok && alu_ok;
    push0_rd = ld_ok ? ld_rd : alu_rd;
    push0_wd = ld_ok ? ld_wd : alu_wd;
  end

  regfile_wb_buffer_wb_fifo #(
    .N     (N),
    .M     (M),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push0_i    (push0),
    .push0_rd_i (push0_rd),
    .push0_wd_i (push0_wd),
    .push1_i    (push1),
    .push1_rd_i (alu_rd),
    .push1_wd_i (alu_wd),
    .pop_i      (rf_we),
    .age_rd_o   (age_rd),
    .age_wd_o   (age_wd),
    .age_vld_o  (age_vld),
    .count_o    (count_q)
  );

  // Any request presented while stalled is lost; remember that until reset.
  always_comb begin
    overflow_d = overflow_q;
    if (stall && (ld_valid || alu_valid)) begin
      overflow_d = 1'b1;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  // Drain port: the head entry is presented whenever the queue is non-empty
  // and is popped on the same edge the register file captures it.
  always_comb begin
    rf_we  = (count_q != '0);
    rf_a3  = '0;
    rf_wd3 = '0;
    if (rf_we) begin
      rf_a3  = age_rd[0];
      rf_wd3 = age_wd[0];
    end
  end

  assign overflow = overflow_q;
  assign count    = count_q;

`ifdef WB_FORWARD_EN
  // Forwarding search, oldest to youngest so the youngest match wins.
  // Entries pushed this cycle are not yet in the age view.
  always_comb begin
    fwd_hit1 = 1'b0;
    fwd_hit2 = 1'b0;
    fwd_d1   = '0;
    fwd_d2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_vld[i] && (fwd_a1 != N'(REG_X0)) && (age_rd[i] == fwd_a1)) begin
        fwd_hit1 = 1'b1;
        fwd_d1   = age_wd[i];
      end
      if (age_vld[i] && (fwd_a2 != N'(REG_X0)) && (age_rd[i] == fwd_a2)) begin
        fwd_hit2 = 1'b1;
        fwd_d2   = age_wd[i];
      end
    end
  end
`else
  // Forwarding not built: outputs are constant zero.
  assign fwd_hit1 = 1'b0;
  assign fwd_hit2 = 1'b0;
  assign fwd_d1   = '0;
  assign fwd_d2   = '0;

  logic unused_fwd;
  assign unused_fwd = ^{fwd_a1, fwd_a2, age_rd, age_wd, age_vld};
`endif

endmodule
